// File: rtl/enc_counter.sv
// enc_counter: conditions a raw quadrature encoder and three push-buttons,
// decodes detents and keeps a saturating 0..MAX_VAL count for seg_driver.
// num/strobe change together; fast selects the step; err flags illegal steps.
module enc_counter #(
  parameter int unsigned DEB_CYCLES = 1000,
  parameter int unsigned MAX_VAL    = 9999,
  parameter int unsigned STEP_FAST  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  encoder,
  input  logic [7:0]  buttons,
  output logic [15:0] num,
  output logic        strobe,
  output logic        fast,
  output logic        err
);

  localparam int          N_IN     = 5;
  localparam logic [15:0] DEB_LAST = 16'(DEB_CYCLES - 1);
  localparam logic [16:0] MAX_W    = 17'(MAX_VAL);
  localparam logic [16:0] STEP_W   = 17'(STEP_FAST);

  // Inputs in one vector: {clear/fast/preset buttons, B, A}
  logic [N_IN-1:0] raw;
  logic            unused_btn;
  assign raw        = {buttons[2:0], encoder};
  assign unused_btn = ^buttons[7:3];

  logic [N_IN-1:0] sync_p0, sync_p1;
  logic            vld_p0, vld_p1;
  logic [N_IN-1:0] deb;
  logic [15:0]     cnt [N_IN];
  logic [1:0]      prev;
  logic [2:0]      btn_prev;
  logic [2:0]      arm;
  logic signed [2:0] acc;

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [16:0] s);
    logic [16:0] sum;
    sum = {1'b0, a} + s;
    return (sum > MAX_W) ? MAX_W[15:0] : sum[15:0];
  endfunction

  function automatic logic [15:0] sat_sub(input logic [15:0] a, input logic [16:0] s);
    logic [16:0] diff;
    diff = {1'b0, a} - s;
    return ({1'b0, a} < s) ? 16'd0 : diff[15:0];
  endfunction

  // Stage p0/p1: two-flop synchroniser; vld marks when p1 holds real samples
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= '1;
      sync_p1 <= '1;
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      vld_p0  <= 1'b1;
      vld_p1  <= vld_p0;
    end
  end

  // Debounce: accept a new level only after DEB_CYCLES consecutive differing cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb <= '1;
      for (int i = 0; i < N_IN; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        if (sync_p1[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DEB_LAST) begin
          deb[i] <= sync_p1[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 16'd1;
        end
      end
    end
  end

  logic [1:0]        enc_deb;
  logic [2:0]        btn_deb;
  logic [2:0]        press;
  logic              step_cw, step_ccw, illegal;
  logic signed [3:0] acc_ext, delta, acc_sum;
  logic              inc_evt, dec_evt;
  logic [16:0]       step;
  logic [15:0]       num_nx;
  logic signed [2:0] acc_nx;
  logic              fast_nx;

  assign enc_deb = deb[1:0];
  assign btn_deb = deb[4:2];
  // A button only counts as pressed once it has been seen released since reset
  assign press   = arm & btn_prev & ~btn_deb;

  // Decode the debounced encoder step and resolve clear > preset > encoder
  always_comb begin
    step_cw  = 1'b0;
    step_ccw = 1'b0;
    illegal  = 1'b0;
    case ({prev, enc_deb})
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_cw  = 1'b1;
      4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: step_ccw = 1'b1;
      4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: illegal  = 1'b1;
      default: ;
    endcase
    acc_ext = {acc[2], acc};
    delta   = step_cw ? 4'sd1 : (step_ccw ? -4'sd1 : 4'sd0);
    acc_sum = acc_ext + delta;
    inc_evt = (acc_sum == 4'sd4);
    dec_evt = (acc_sum == -4'sd4);
    step    = fast ? STEP_W : 17'd1;
    num_nx  = num;
    acc_nx  = acc;
    fast_nx = fast ^ press[1];
    if (press[0]) begin
      num_nx = 16'd0;
      acc_nx = 3'sd0;
    end else if (press[2]) begin
      num_nx = MAX_W[15:0];
      acc_nx = 3'sd0;
    end else begin
      acc_nx = (inc_evt || dec_evt) ? 3'sd0 : acc_sum[2:0];
      if (inc_evt)      num_nx = sat_add(num, step);
      else if (dec_evt) num_nx = sat_sub(num, step);
    end
  end

  // Stage p2: register count, strobe on change, mode, error pulse and history
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      num      <= '0;
      strobe   <= 1'b0;
      fast     <= 1'b0;
      err      <= 1'b0;
      acc      <= 3'sd0;
      prev     <= 2'b11;
      btn_prev <= 3'b111;
      arm      <= 3'b000;
    end else begin
      num      <= num_nx;
      strobe   <= (num_nx != num);
      fast     <= fast_nx;
      err      <= illegal;
      acc      <= acc_nx;
      prev     <= enc_deb;
      btn_prev <= btn_deb;
      arm      <= arm | ({3{vld_p1}} & sync_p1[4:2]);
    end
  end

endmodule

// File: tb/tb_enc_counter.sv
// Directed bench for enc_counter with DEB_CYCLES=4, MAX_VAL=9999, STEP_FAST=10.
module tb_enc_counter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  encoder = 2'b11;
  logic [7:0]  buttons = 8'hFF;
  logic [15:0] num;
  logic        strobe, fast, err;

  int n_checks = 0;
  int n_errors = 0;
  int strobe_cnt = 0;
  int err_cnt = 0;
  int s0, e0;

  always #5 clk = ~clk;

  enc_counter #(.DEB_CYCLES(4), .MAX_VAL(9999), .STEP_FAST(10)) dut (
    .clk(clk), .reset(reset), .encoder(encoder), .buttons(buttons),
    .num(num), .strobe(strobe), .fast(fast), .err(err)
  );

  // Count strobe and err pulses, sampled on the falling edge
  always @(negedge clk) begin
    if (strobe) strobe_cnt <= strobe_cnt + 1;
    if (err)    err_cnt    <= err_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [1:0] cw_next(input logic [1:0] p);
    case (p)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] ccw_next(input logic [1:0] p);
    case (p)
      2'b01:   return 2'b00;
      2'b11:   return 2'b01;
      2'b10:   return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  task automatic move(input bit cw, input int steps);
    for (int i = 0; i < steps; i++) begin
      encoder = cw ? cw_next(encoder) : ccw_next(encoder);
      wait_cyc(10);
    end
  endtask

  task automatic press(input int b);
    buttons[b] = 1'b0;
    wait_cyc(10);
    buttons[b] = 1'b1;
    wait_cyc(10);
  endtask

  initial begin
    wait_cyc(3);
    check("rst_num", 32'(num), 0);
    check("rst_strobe", 32'(strobe), 0);
    check("rst_fast", 32'(fast), 0);
    check("rst_err", 32'(err), 0);
    reset = 1'b1;
    wait_cyc(10);

    // 1: one CW detent with exact strobe timing, then one CCW detent
    s0 = strobe_cnt; e0 = err_cnt;
    move(1'b1, 3);
    encoder = cw_next(encoder);
    wait_cyc(6);
    check("t1_num_before", 32'(num), 0);
    check("t1_strobe_before", 32'(strobe), 0);
    wait_cyc(1);
    check("t1_num_after", 32'(num), 1);
    check("t1_strobe_on", 32'(strobe), 1);
    wait_cyc(1);
    check("t1_strobe_off", 32'(strobe), 0);
    wait_cyc(7);
    check("t1_strobe_count", 32'(strobe_cnt - s0), 1);
    check("t1_err_count", 32'(err_cnt - e0), 0);
    s0 = strobe_cnt;
    move(1'b0, 4);
    check("t1_ccw_num", 32'(num), 0);
    check("t1_ccw_strobes", 32'(strobe_cnt - s0), 1);

    // 2: 3-cycle glitch rejected, 4-cycle glitch accepted
    s0 = strobe_cnt; e0 = err_cnt;
    encoder = 2'b10;
    wait_cyc(3);
    encoder = 2'b11;
    wait_cyc(10);
    check("t2_short_acc", {29'd0, dut.acc}, 0);
    check("t2_short_num", 32'(num), 0);
    encoder = 2'b10;
    wait_cyc(4);
    encoder = 2'b11;
    wait_cyc(3);
    check("t2_long_acc_up", {29'd0, dut.acc}, 1);
    wait_cyc(10);
    check("t2_long_acc_back", {29'd0, dut.acc}, 0);
    check("t2_num", 32'(num), 0);
    check("t2_strobes", 32'(strobe_cnt - s0), 0);
    check("t2_errs", 32'(err_cnt - e0), 0);

    // 3: saturation at both ends and preset
    s0 = strobe_cnt;
    move(1'b0, 4);
    check("t3_floor_num", 32'(num), 0);
    check("t3_floor_strobes", 32'(strobe_cnt - s0), 0);
    press(2);
    check("t3_preset_num", 32'(num), 9999);
    check("t3_preset_strobes", 32'(strobe_cnt - s0), 1);
    s0 = strobe_cnt;
    move(1'b1, 4);
    check("t3_ceil_num", 32'(num), 9999);
    check("t3_ceil_strobes", 32'(strobe_cnt - s0), 0);

    // 4: fast mode steps
    press(0);
    check("t4_clear", 32'(num), 0);
    press(1);
    check("t4_fast_on", 32'(fast), 1);
    move(1'b1, 12);
    check("t4_up30", 32'(num), 30);
    press(1);
    check("t4_fast_off", 32'(fast), 0);
    press(0);
    move(1'b1, 20);
    check("t4_five", 32'(num), 5);
    press(1);
    move(1'b0, 4);
    check("t4_down_floor", 32'(num), 0);
    press(1);
    press(2);
    move(1'b0, 16);
    check("t4_9995", 32'(num), 9995);
    press(1);
    move(1'b1, 4);
    check("t4_up_ceil", 32'(num), 9999);
    check("t4_fast", 32'(fast), 1);

    // 5: illegal step, then clear racing an increment event
    s0 = strobe_cnt; e0 = err_cnt;
    encoder = 2'b00;
    wait_cyc(6);
    check("t5_err_before", 32'(err), 0);
    wait_cyc(1);
    check("t5_err_pulse", 32'(err), 1);
    wait_cyc(1);
    check("t5_err_after", 32'(err), 0);
    wait_cyc(5);
    check("t5_err_count", 32'(err_cnt - e0), 1);
    check("t5_err_acc", {29'd0, dut.acc}, 0);
    check("t5_err_num", 32'(num), 9999);
    move(1'b1, 3);
    check("t5_acc3", {29'd0, dut.acc}, 3);
    buttons[0] = 1'b0;
    encoder = cw_next(encoder);
    wait_cyc(10);
    buttons[0] = 1'b1;
    wait_cyc(10);
    check("t5_clear_wins_num", 32'(num), 0);
    check("t5_clear_wins_acc", {29'd0, dut.acc}, 0);
    check("t5_strobes", 32'(strobe_cnt - s0), 1);

    // 6: asynchronous reset mid-count, button held through release
    move(1'b1, 48);
    press(1);
    move(1'b1, 12);
    press(1);
    check("t6_num123", 32'(num), 123);
    check("t6_fast", 32'(fast), 1);
    move(1'b1, 2);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_num", 32'(num), 0);
    check("t6_rst_strobe", 32'(strobe), 0);
    check("t6_rst_fast", 32'(fast), 0);
    check("t6_rst_err", 32'(err), 0);
    buttons[0] = 1'b0;
    wait_cyc(3);
    reset = 1'b1;
    s0 = strobe_cnt; e0 = err_cnt;
    wait_cyc(20);
    check("t6_idle_strobes", 32'(strobe_cnt - s0), 0);
    check("t6_idle_errs", 32'(err_cnt - e0), 0);
    move(1'b1, 4);
    check("t6_held_no_clear", 32'(num), 1);
    buttons[0] = 1'b1;
    wait_cyc(10);
    check("t6_release_no_clear", 32'(num), 1);
    press(0);
    check("t6_press_clears", 32'(num), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/enc_counter.md
# enc_counter

Input-conditioning stage that sits directly upstream of the seven-segment `seg_driver`. It synchronises and debounces the raw quadrature encoder and push-buttons, decodes encoder detents, and maintains a saturating 0..MAX_VAL count. It presents that count on `num` with a one-cycle `strobe` whenever the value changes, and these two outputs connect straight to the display driver's `num` and `strobe` inputs.

## Interface
- `DEB_CYCLES`, default 1000: consecutive stable cycles required before a synchronised input is accepted; legal range 1..65535.
- `MAX_VAL`, default 9999: upper saturation bound for `num`; must be ≤ 65535.
- `STEP_FAST`, default 10: count step used in fast mode; must be ≥ 1 and ≤ MAX_VAL.
- `clk`  in  1: system clock; all flops rise-edge.
- `reset`  in  1: asynchronous, active-low; every flop is cleared while it is low.
- `encoder`  in  2: raw quadrature {B,A}, asynchronous to `clk`.
- `buttons`  in  8: raw push-buttons, active-low, asynchronous. Bit 0 = clear, bit 1 = fast toggle, bit 2 = preset. Bits 7:3 are ignored.
- `num`  out  16: current count, unsigned, 0..MAX_VAL.
- `strobe`  out  1: high for exactly one cycle, in the first cycle `num` shows a new value.
- `fast`  out  1: 1 = fast mode (step STEP_FAST), 0 = step 1.
- `err`  out  1: one-cycle pulse on an illegal quadrature transition.

## Operation
- Synchroniser: 2-flop chain on each of the 5 used inputs (A, B, buttons[2:0]).
- Debouncer, per input:
  - A 16-bit counter plus a debounced value `deb`.
  - If the synchronised value equals `deb`, the counter is cleared.
  - Otherwise the counter increments. When it reaches DEB_CYCLES, `deb` takes the synchronised value and the counter clears.
  - A glitch shorter than DEB_CYCLES cycles therefore has no effect.
- Quadrature decode:
  - Registered `prev` holds the last debounced {B,A}; it is compared with the current debounced {B,A}.
  - CW sequence is 00→01→11→10→00; each such transition adds +1 to a signed 3-bit sub-step accumulator `acc`.
  - A reverse transition adds −1.
  - A transition with both bits changed is illegal: `err` pulses and `acc` is unchanged.
  - When `acc` would reach +4, the result is an increment event and `acc` goes to 0. Reaching −4 gives a decrement event and `acc` goes to 0.
- Buttons: a press is the falling edge of the debounced, active-low level. Each press produces one event per physical press.
  - Clear: `num` = 0 and `acc` = 0.
  - Preset: `num` = MAX_VAL and `acc` = 0.
  - Fast toggle: `fast` inverts.
- Count arithmetic uses a 17-bit intermediate with step s = `fast` ? STEP_FAST : 1.
  - Increment: `num` = min(`num`+s, MAX_VAL).
  - Decrement: `num` = (`num` < s) ? 0 : `num`−s.
  - There is no wrap-around in either direction.
- Priority for events in the same cycle: clear > preset > encoder event. A fast toggle in the same cycle as an encoder event takes effect from the next event; the current event uses the old step.
- `strobe` is asserted only when the registered `num` differs from its previous value. A step while saturated, or a clear at 0, produces no strobe.

## Timing
- Reset values: `num` = 0, `strobe` = 0, `fast` = 0, `err` = 0, `acc` = 0, all `deb` = 1 (idle level), `prev` = 11, debounce counters = 0.
- Let E0 be the first rising edge that samples a raw input change:
  - Synchroniser output changes at E1.
  - `deb` changes at E(1+DEB_CYCLES).
  - `num`, `strobe`, `acc`, `err`, `fast` update at E(2+DEB_CYCLES).
  - Total latency is DEB_CYCLES+2 edges.
- `strobe` is registered together with `num`, so both change on the same edge.
- Reset mid-operation: all state returns to reset values asynchronously. Inputs held at their idle level produce no events after reset release. A button held low through reset release produces no press; it must return high first.
- At most one `num` update per cycle; events are never queued.

## Test plan
Bench parameters: DEB_CYCLES = 4, MAX_VAL = 9999, STEP_FAST = 10; inputs idle at {B,A} = 11, buttons = 8'hFF.
1. Reset, then 4 clean CW Gray steps, each held 10 cycles, starting from 11 (11→10→00→01→11) → `num` = 1, one `strobe` pulse 6 edges after the fourth change, `err` = 0. Four CCW steps → `num` = 0, one `strobe`.
2. Glitch on A lasting 3 cycles → no change to `deb`, `num` or `strobe`. A 4-cycle glitch is accepted as a transition and `acc` changes.
3. With `num` = 0, one CCW detent → `num` stays 0 and no `strobe`. Then press preset → `num` = 9999 with a strobe. One CW detent → `num` stays 9999 and no strobe.
4. Press fast (`fast` = 1). From 0, 3 CW detents → `num` = 30. From 5, one CCW detent → `num` = 0. From 9995, one CW detent → `num` = 9999.
5. Direct 11→00 change on the encoder → `err` pulses one cycle, `acc` and `num` unchanged. Clear and an encoder event resolved on the same edge → `num` = 0.
6. Drive `reset` low mid-count (`num` = 123, `fast` = 1) → all outputs 0 immediately. With button 0 held low through reset release → no clear event until it is released and pressed again.
